// File: rtl/vec_alu_lanes.sv
// vec_alu_lanes: executes one RVV integer arithmetic/logic instruction over a
// whole vector register, NB_LANES elements per cycle, with vl clamping, v0
// masking and undisturbed inactive/tail elements.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             launch request, sampled only in IDLE
//   opcode, op_type   RVV funct6 and operand form (001 VV, 010 VX, 100 VI)
//   vsew              element width select (000=8, 001=16, 010=32)
//   vl, vm, v0_mask   active length, mask enable (0 = masked), mask bits
//   vs1_in, vs2_in    vector sources; vd_old = prior destination contents
//   rs1, imm5         scalar / immediate operand
//   vd                result register, valid from done onward
//   busy, done        busy while iterating; done is a one-cycle pulse
//   illegal           valid with done; unsupported opcode/op_type/vsew
module vec_alu_lanes #(
  parameter int VLEN     = 128,
  parameter int ELEN     = 32,
  parameter int NB_LANES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      opcode,
  input  logic [2:0]      op_type,
  input  logic [2:0]      vsew,
  input  logic [10:0]     vl,
  input  logic            vm,
  input  logic [VLEN-1:0] v0_mask,
  input  logic [VLEN-1:0] vs1_in,
  input  logic [VLEN-1:0] vs2_in,
  input  logic [VLEN-1:0] vd_old,
  input  logic [31:0]     rs1,
  input  logic [4:0]      imm5,
  output logic [VLEN-1:0] vd,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000010,
                         OP_RSUB = 6'b000011, OP_MINU = 6'b000100,
                         OP_MIN  = 6'b000101, OP_MAXU = 6'b000110,
                         OP_MAX  = 6'b000111, OP_AND  = 6'b001001,
                         OP_OR   = 6'b001010, OP_XOR  = 6'b001011,
                         OP_SLL  = 6'b100101, OP_SRL  = 6'b101000,
                         OP_SRA  = 6'b101001;
  localparam logic [10:0] LANES = 11'(NB_LANES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [10:0]     elem_q, vl_q, vl_eff, vlmax_in;
  logic            illegal_q, bad_in, type_ok, sew_ok, op_ok;
  logic [VLEN-1:0] vd_nxt;

  // Operands captured at launch; data only, so no reset.
  logic [5:0]      opcode_p0;
  logic [2:0]      op_type_p0;
  logic [1:0]      vsew_p0;
  logic            vm_p0;
  logic [VLEN-1:0] v0_p0, vs1_p0, vs2_p0;
  logic [31:0]     rs1_p0;
  logic [4:0]      imm5_p0;

  function automatic logic [31:0] sew_mask(input logic [1:0] sw);
    case (sw)
      2'd0:    return 32'h0000_00FF;
      2'd1:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic signed [31:0] sext(input logic [31:0] x, input logic [1:0] sw);
    case (sw)
      2'd0:    return $signed({{24{x[7]}}, x[7:0]});
      2'd1:    return $signed({{16{x[15]}}, x[15:0]});
      default: return $signed(x);
    endcase
  endfunction

  function automatic logic [31:0] get_elem(input logic [VLEN-1:0] v, input logic [10:0] e,
                                           input logic [1:0] sw);
    int unsigned pos;
    pos = 32'(e) << (32'd3 + 32'(sw));
    return 32'(v >> pos) & sew_mask(sw);
  endfunction

  function automatic logic [VLEN-1:0] put_elem(input logic [VLEN-1:0] v, input logic [10:0] e,
                                               input logic [1:0] sw, input logic [31:0] x);
    int unsigned     pos;
    logic [VLEN-1:0] m, d;
    pos = 32'(e) << (32'd3 + 32'(sw));
    m = '0;
    m[31:0] = sew_mask(sw);
    d = '0;
    d[31:0] = x & sew_mask(sw);
    return (v & ~(m << pos)) | (d << pos);
  endfunction

  // a and b arrive zero-extended from SEW; signed ops re-extend them.
  function automatic logic [31:0] alu(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [1:0] sw);
    logic signed [31:0] sa, sb;
    logic [4:0]         sh;
    logic [31:0]        r;
    sa = sext(a, sw);
    sb = sext(b, sw);
    sh = a[4:0] & ((sw == 2'd0) ? 5'd7 : (sw == 2'd1) ? 5'd15 : 5'd31);
    case (op)
      OP_ADD:  r = b + a;
      OP_SUB:  r = b - a;
      OP_RSUB: r = a - b;
      OP_MINU: r = (a < b) ? a : b;
      OP_MIN:  r = (sa < sb) ? a : b;
      OP_MAXU: r = (a > b) ? a : b;
      OP_MAX:  r = (sa > sb) ? a : b;
      OP_AND:  r = b & a;
      OP_OR:   r = b | a;
      OP_XOR:  r = b ^ a;
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      OP_SRA:  r = $unsigned(sb >>> sh);
      default: r = b;
    endcase
    return r;
  endfunction

  // Launch-time decode and vl clamp, straight from the ports.
  always_comb begin
    type_ok = (op_type == 3'b001) || (op_type == 3'b010) || (op_type == 3'b100);
    sew_ok  = (vsew <= 3'd2) && ((32'd8 << vsew) <= 32'(ELEN));
    case (opcode)
      OP_ADD, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA:               op_ok = 1'b1;
      OP_SUB, OP_MINU, OP_MIN, OP_MAXU,
      OP_MAX:                               op_ok = (op_type != 3'b100);
      OP_RSUB:                              op_ok = (op_type != 3'b001);
      default:                              op_ok = 1'b0;
    endcase
    bad_in = !(op_ok && type_ok && sew_ok);
    case (vsew[1:0])
      2'd0:    vlmax_in = 11'(VLEN / 8);
      2'd1:    vlmax_in = 11'(VLEN / 16);
      default: vlmax_in = 11'(VLEN / 32);
    endcase
    vl_eff = (vl > vlmax_in) ? vlmax_in : vl;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = (bad_in || vl_eff == 11'd0) ? S_DONE : S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if ({1'b0, elem_q} + {1'b0, LANES} >= {1'b0, vl_q}) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = illegal_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      opcode_p0  <= opcode;
      op_type_p0 <= op_type;
      vsew_p0    <= vsew[1:0];
      vm_p0      <= vm;
      v0_p0      <= v0_mask;
      vs1_p0     <= vs1_in;
      vs2_p0     <= vs2_in;
      rs1_p0     <= rs1;
      imm5_p0    <= imm5;
    end
  end

  // Lanes: element e = elem_q + k, written only if active, otherwise left as is.
  logic [10:0] lane_e;
  logic [31:0] lane_a, lane_b;
  logic        lane_shift;
  always_comb begin
    vd_nxt     = vd;
    lane_e     = '0;
    lane_a     = '0;
    lane_b     = '0;
    lane_shift = (opcode_p0 == OP_SLL) || (opcode_p0 == OP_SRL) || (opcode_p0 == OP_SRA);
    for (int k = 0; k < NB_LANES; k++) begin
      lane_e = elem_q + 11'(k);
      lane_b = get_elem(vs2_p0, lane_e, vsew_p0);
      case (op_type_p0)
        3'b001:  lane_a = get_elem(vs1_p0, lane_e, vsew_p0);
        3'b010:  lane_a = rs1_p0 & sew_mask(vsew_p0);
        default: lane_a = (lane_shift ? {27'd0, imm5_p0} : {{27{imm5_p0[4]}}, imm5_p0})
                          & sew_mask(vsew_p0);
      endcase
      if (lane_e < vl_q && (vm_p0 || 1'(v0_p0 >> lane_e)))
        vd_nxt = put_elem(vd_nxt, lane_e, vsew_p0,
                          alu(opcode_p0, lane_a, lane_b, vsew_p0));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vd        <= '0;
      elem_q    <= '0;
      vl_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          vd        <= vd_old;
          elem_q    <= '0;
          vl_q      <= vl_eff;
          illegal_q <= bad_in;
        end
        S_RUN: begin
          vd     <= vd_nxt;
          elem_q <= elem_q + LANES;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_lanes.sv
// Directed bench for vec_alu_lanes (VLEN=128, ELEN=32, NB_LANES=4).
module tb_vec_alu_lanes;
  logic         clk, reset, start, vm, busy, done, illegal;
  logic [5:0]   opcode;
  logic [2:0]   op_type, vsew;
  logic [10:0]  vl;
  logic [127:0] v0_mask, vs1_in, vs2_in, vd_old, vd;
  logic [31:0]  rs1;
  logic [4:0]   imm5;
  int           errors = 0, checks = 0, cyc, dcount;
  logic         ill;

  vec_alu_lanes #(.VLEN(128), .ELEN(32), .NB_LANES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .op_type(op_type),
    .vsew(vsew), .vl(vl), .vm(vm), .v0_mask(v0_mask), .vs1_in(vs1_in),
    .vs2_in(vs2_in), .vd_old(vd_old), .rs1(rs1), .imm5(imm5), .vd(vd),
    .busy(busy), .done(done), .illegal(illegal));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [5:0] op, input logic [2:0] ty, input logic [2:0] sw,
                       input logic [10:0] l, input logic m, input logic [127:0] v0,
                       input logic [127:0] s1, input logic [127:0] s2,
                       input logic [127:0] old, input logic [31:0] r, input logic [4:0] im);
    opcode = op; op_type = ty; vsew = sw; vl = l; vm = m; v0_mask = v0;
    vs1_in = s1; vs2_in = s2; vd_old = old; rs1 = r; imm5 = im;
  endtask

  // Launch, count cycles from the start cycle until done (bounded), then
  // step into IDLE so the next launch is accepted.
  task automatic go(output int c, output logic il);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    c = 1;
    while (!done && c < 64) begin @(posedge clk); #1; c++; end
    il = illegal;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    setup(6'd0, 3'b001, 3'b000, 11'd0, 1'b1, '0, '0, '0, '0, 32'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_v("reset_vd", vd, '0);
    chk_i("reset_busy", 32'(busy), 32'd0);
    chk_i("reset_done", 32'(done), 32'd0);
    chk_i("reset_illegal", 32'(illegal), 32'd0);
    @(negedge clk); reset = 1'b0;

    // vadd VV SEW8 vl16: 0xFF + 0x02 wraps to 0x01 in every byte
    setup(6'b000000, 3'b001, 3'b000, 11'd16, 1'b1, '0, {16{8'hFF}}, {16{8'h02}},
          128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 32'd0, 5'd0);
    go(cyc, ill);
    chk_v("vadd_vv_vd", vd, {16{8'h01}});
    chk_i("vadd_vv_lat", 32'(cyc), 32'd5);
    chk_i("vadd_vv_ill", 32'(ill), 32'd0);

    // vsub VX SEW32 vl3: tail element 3 keeps vd_old
    setup(6'b000010, 3'b010, 3'b010, 11'd3, 1'b1, '0, '0, {32'd40, 32'd30, 32'd20, 32'd10},
          {32'hDEADBEEF, {3{32'hAAAA_AAAA}}}, 32'd5, 5'd0);
    go(cyc, ill);
    chk_v("vsub_vx_vd", vd, {32'hDEADBEEF, 32'd25, 32'd15, 32'd5});
    chk_i("vsub_vx_lat", 32'(cyc), 32'd2);

    // vmax VV SEW16 masked by 0x00AA: odd elements 0x0001, even keep vd_old
    setup(6'b000111, 3'b001, 3'b001, 11'd8, 1'b0, 128'h00AA, {8{16'h8000}}, {8{16'h0001}},
          128'h7777_6666_5555_4444_3333_2222_1111_0000, 32'd0, 5'd0);
    go(cyc, ill);
    chk_v("vmax_masked_vd", vd, 128'h0001_6666_0001_4444_0001_2222_0001_0000);
    chk_i("vmax_masked_lat", 32'(cyc), 32'd3);

    // vsra VI: imm5 zero-extended, 31 & 7 = 7, 0x80 >>> 7 = 0xFF
    setup(6'b101001, 3'b100, 3'b000, 11'd16, 1'b1, '0, '0, {16{8'h80}}, '0, 32'd0, 5'h1F);
    go(cyc, ill);
    chk_v("vsra_vi_vd", vd, {16{8'hFF}});

    // vsll VI 3 on 0x11, vl=4 leaves upper bytes at vd_old
    setup(6'b100101, 3'b100, 3'b000, 11'd4, 1'b1, '0, '0, {16{8'h11}}, '0, 32'd0, 5'd3);
    go(cyc, ill);
    chk_v("vsll_vi_vd", vd, 128'h8888_8888);
    chk_i("vsll_vi_lat", 32'(cyc), 32'd2);

    // vrsub VI: imm 0x1F sign-extends to 0xFF, 0xFF - 0x05 = 0xFA
    setup(6'b000011, 3'b100, 3'b000, 11'd16, 1'b1, '0, '0, {16{8'h05}}, '0, 32'd0, 5'h1F);
    go(cyc, ill);
    chk_v("vrsub_vi_vd", vd, {16{8'hFA}});

    // vmin vs vminu VX SEW16 with 0x8000 against 0x0001
    setup(6'b000101, 3'b010, 3'b001, 11'd8, 1'b1, '0, '0, {8{16'h0001}}, '0, 32'hFFFF_8000, 5'd0);
    go(cyc, ill);
    chk_v("vmin_vx_vd", vd, {8{16'h8000}});
    setup(6'b000100, 3'b010, 3'b001, 11'd8, 1'b1, '0, '0, {8{16'h0001}}, '0, 32'hFFFF_8000, 5'd0);
    go(cyc, ill);
    chk_v("vminu_vx_vd", vd, {8{16'h0001}});

    // vl=20 at SEW32 clamps to VLMAX=4
    setup(6'b000000, 3'b010, 3'b010, 11'd20, 1'b1, '0, '0, {32'd4, 32'd3, 32'd2, 32'd1},
          '1, 32'd1, 5'd0);
    go(cyc, ill);
    chk_v("vl_clamp_vd", vd, {32'd5, 32'd4, 32'd3, 32'd2});
    chk_i("vl_clamp_lat", 32'(cyc), 32'd2);

    // vl=0: no RUN, vd = vd_old
    setup(6'b000000, 3'b001, 3'b000, 11'd0, 1'b1, '0, '1, '1, 128'hCAFE_F00D, 32'd0, 5'd0);
    go(cyc, ill);
    chk_v("vl0_vd", vd, 128'hCAFE_F00D);
    chk_i("vl0_lat", 32'(cyc), 32'd1);
    chk_i("vl0_ill", 32'(ill), 32'd0);

    // Illegal launches: bad opcode, SEW>ELEN, vsub VI, op_type not one-hot
    setup(6'h3F, 3'b001, 3'b000, 11'd16, 1'b1, '0, '1, '1, 128'h1234_5678, 32'd0, 5'd0);
    go(cyc, ill);
    chk_v("badop_vd", vd, 128'h1234_5678);
    chk_i("badop_lat", 32'(cyc), 32'd1);
    chk_i("badop_ill", 32'(ill), 32'd1);
    setup(6'b000000, 3'b001, 3'b011, 11'd2, 1'b1, '0, '1, '1, 128'h55, 32'd0, 5'd0);
    go(cyc, ill);
    chk_i("badsew_ill", 32'(ill), 32'd1);
    chk_v("badsew_vd", vd, 128'h55);
    setup(6'b000010, 3'b100, 3'b000, 11'd4, 1'b1, '0, '0, '1, '0, 32'd0, 5'd1);
    go(cyc, ill);
    chk_i("vsub_vi_ill", 32'(ill), 32'd1);
    setup(6'b000000, 3'b011, 3'b000, 11'd4, 1'b1, '0, '0, '1, '0, 32'd0, 5'd1);
    go(cyc, ill);
    chk_i("optype_ill", 32'(ill), 32'd1);

    // Reset mid-RUN aborts with no done pulse
    setup(6'b000000, 3'b001, 3'b000, 11'd16, 1'b1, '0, {16{8'hFF}}, {16{8'h02}}, '0, 32'd0, 5'd0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk_i("run_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_v("abort_vd", vd, '0);
    chk_i("abort_busy", 32'(busy), 32'd0);
    chk_i("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    dcount = 0;
    repeat (8) begin @(posedge clk); #1; if (done) dcount++; end
    chk_i("abort_no_done", 32'(dcount), 32'd0);
    go(cyc, ill);
    chk_v("after_abort_vd", vd, {16{8'h01}});
    chk_i("after_abort_lat", 32'(cyc), 32'd5);

    // start pulsed during RUN (with changed vs1) and during DONE is ignored
    vd_old = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1;
    while (!done && cyc < 64) begin
      if (cyc == 2) begin start = 1'b1; vs1_in = '0; end
      else start = 1'b0;
      @(posedge clk); #1; cyc++;
    end
    start = 1'b1;
    chk_i("busy_start_lat", 32'(cyc), 32'd5);
    chk_v("busy_start_vd", vd, {16{8'h01}});
    @(posedge clk); #1; start = 1'b0;
    chk_i("done_start_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk_i("done_start_idle", 32'(busy | done), 32'd0);
    chk_v("vd_hold", vd, {16{8'h01}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
